// File: rtl/xbus_uart.sv
// Memory-mapped 8N1 UART responder on the xbus: TX FIFO + serializer, RX deserializer + FIFO,
// programmable baud divisor and a registered level interrupt. Read data is combinational.
module xbus_uart #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RST    = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        xbus_as_i,
  input  logic        xbus_we_i,
  input  logic [3:0]  xbus_be_i,
  input  logic [31:0] xbus_addr_i,
  input  logic [31:0] xbus_wdata_i,
  output logic [31:0] xbus_rdata_o,
  output logic        uart_tx_o,
  input  logic        uart_rx_i,
  output logic        irq_o
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic       sel, wr;
  logic [1:0] idx;
  assign sel = xbus_as_i & (xbus_addr_i[31:4] == BASE_ADDR[31:4]);
  assign wr  = sel & xbus_we_i & (xbus_be_i != 4'b0);
  assign idx = xbus_addr_i[3:2];

  logic [15:0] baud_q, baud_d, baud_new;
  logic        ie_rx_q, ie_rx_d, ie_tx_q, ie_tx_d;
  logic        tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d, frm_err_q, frm_err_d;
  logic        irq_q, irq_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;

  // TX FIFO
  logic [7:0]  tx_mem_q [FIFO_DEPTH];
  logic [AW:0] tx_wp_q, tx_rp_q;
  logic        tx_empty, tx_full, tx_push_req, tx_push, tx_pop, tx_busy;
  assign tx_empty    = tx_wp_q == tx_rp_q;
  assign tx_full     = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
  assign tx_push_req = wr & (idx == 2'd0) & xbus_be_i[0];
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp_q <= '0;
      tx_rp_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q[AW-1:0]] <= xbus_wdata_i[7:0];
  end

  // TX FSM
  state_e      tx_state_q, tx_state_d;
  logic [15:0] tx_div_q, tx_div_d, tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_last;
  assign tx_last = tx_cnt_q == tx_div_q - 16'd1;
  assign tx_busy = (tx_state_q != StIdle) | ~tx_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= StIdle;
      tx_div_q   <= DIV_RST;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_div_q   <= tx_div_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_div_d   = tx_div_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    unique case (tx_state_q)
      StIdle: begin
        tx_cnt_d = '0;
        if (!tx_empty) begin
          tx_state_d = StStart;
          tx_div_d   = baud_q;
          tx_sh_d    = tx_mem_q[tx_rp_q[AW-1:0]];
        end
      end
      StStart: if (tx_last) begin
        tx_state_d = StData;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
      end
      StData: if (tx_last) begin
        tx_cnt_d = '0;
        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
        tx_bit_d = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_state_d = StStop;
      end
      StStop: if (tx_last) begin
        tx_state_d = StIdle;
        tx_cnt_d   = '0;
      end
      default: tx_state_d = StIdle;
    endcase
  end

  always_comb begin
    uart_tx_o = 1'b1;
    tx_pop    = 1'b0;
    unique case (tx_state_q)
      StIdle:  tx_pop    = ~tx_empty;
      StStart: uart_tx_o = 1'b0;
      StData:  uart_tx_o = tx_sh_q[0];
      default: ;
    endcase
  end

  // RX FSM
  state_e      rx_state_q, rx_state_d;
  logic [15:0] rx_div_q, rx_div_d, rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_fall, rx_mid, rx_last, rx_done, rx_bad;
  assign rx_fall = rx_prev_q & ~rx_s2_q;
  assign rx_last = rx_cnt_q == rx_div_q - 16'd1;
  assign rx_mid  = rx_cnt_q == (rx_div_q >> 1) - 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= StIdle;
      rx_div_q   <= DIV_RST;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_div_q   <= rx_div_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_div_d   = rx_div_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    unique case (rx_state_q)
      StIdle: begin
        rx_cnt_d = '0;
        if (rx_fall) begin
          rx_state_d = StStart;
          rx_div_d   = baud_q;
        end
      end
      StStart: if (rx_mid) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? StIdle : StData;
      end
      StData: if (rx_last) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = StStop;
      end
      StStop: if (rx_last) rx_state_d = StIdle;
      default: rx_state_d = StIdle;
    endcase
  end

  always_comb begin
    rx_done = 1'b0;
    rx_bad  = 1'b0;
    if (rx_state_q == StStop && rx_last) begin
      rx_done = rx_s2_q;
      rx_bad  = ~rx_s2_q;
    end
  end

  // RX FIFO
  logic [7:0]  rx_mem_q [FIFO_DEPTH];
  logic [AW:0] rx_wp_q, rx_rp_q;
  logic        rx_empty, rx_full, rx_push, rx_pop;
  logic [7:0]  rx_head;
  assign rx_empty = rx_wp_q == rx_rp_q;
  assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
  assign rx_pop   = wr & (idx == 2'd1) & ~rx_empty;
  assign rx_push  = rx_done & (~rx_full | rx_pop);
  assign rx_head  = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp_q <= '0;
      rx_rp_q <= '0;
    end else begin
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wp_q[AW-1:0]] <= rx_sh_q;
  end

  // Control registers, sticky flags (set wins over W1C) and interrupt
  logic       w1c, div_wr;
  logic [6:0] status;
  assign w1c    = wr & (idx == 2'd2) & xbus_be_i[0];
  assign div_wr = wr & (idx == 2'd3);
  assign status = {frm_err_q, rx_ovf_q, tx_ovf_q, rx_full, ~rx_empty, tx_busy, tx_full};

  always_comb begin
    baud_new = {xbus_be_i[1] ? xbus_wdata_i[15:8] : baud_q[15:8],
                xbus_be_i[0] ? xbus_wdata_i[7:0]  : baud_q[7:0]};
    baud_d   = baud_q;
    ie_rx_d  = ie_rx_q;
    ie_tx_d  = ie_tx_q;
    if (div_wr && (xbus_be_i[0] || xbus_be_i[1])) baud_d = (baud_new < 16'd4) ? 16'd4 : baud_new;
    if (div_wr && xbus_be_i[2]) {ie_tx_d, ie_rx_d} = xbus_wdata_i[17:16];
    tx_ovf_d  = (tx_push_req & ~tx_push) | (tx_ovf_q & ~(w1c & xbus_wdata_i[4]));
    rx_ovf_d  = (rx_done & ~rx_push) | (rx_ovf_q & ~(w1c & xbus_wdata_i[5]));
    frm_err_d = rx_bad | (frm_err_q & ~(w1c & xbus_wdata_i[6]));
    irq_d     = (ie_rx_q & ~rx_empty) | (ie_tx_q & ~tx_busy);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_q    <= DIV_RST;
      ie_rx_q   <= 1'b0;
      ie_tx_q   <= 1'b0;
      tx_ovf_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
      frm_err_q <= 1'b0;
      irq_q     <= 1'b0;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      baud_q    <= baud_d;
      ie_rx_q   <= ie_rx_d;
      ie_tx_q   <= ie_tx_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_ovf_q  <= rx_ovf_d;
      frm_err_q <= frm_err_d;
      irq_q     <= irq_d;
      rx_s1_q   <= uart_rx_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign irq_o = irq_q;

  always_comb begin
    logic [31:0] rdata;
    rdata = '0;
    unique case (idx)
      2'd0: rdata = '0;
      2'd1: rdata = {23'b0, ~rx_empty, rx_head};
      2'd2: rdata = {25'b0, status};
      2'd3: rdata = {14'b0, ie_tx_q, ie_rx_q, baud_q};
      default: rdata = '0;
    endcase
    xbus_rdata_o = (sel & ~xbus_we_i) ? rdata : 32'h0;
  end

endmodule
